processing_unit_neo_mc: RTL and testbench

Multi-channel, parametrised successor to the single-channel NEO processing unit. It accepts a time-multiplexed stream of samples tagged with a channel index. Per channel it computes the nonlinear energy operator psi = x[n-1]^2 - x[n]*x[n-2] and compares it against a programmable threshold, then applies a per-channel refractory period. Detections appear as per-channel pulses and as timestamped event words in an output FIFO with a valid/ready handshake. It sits between the front-end sample mux and the downstream event classifier/packetiser.

---
 rtl/processing_unit_neo_mc.sv | 169 ++++++++++++++++
 tb/tb_processing_unit_neo_mc.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processing_unit_neo_mc.sv
// processing_unit_neo_mc: multi-channel nonlinear energy operator (NEO) spike
// detector. Time-multiplexed samples are processed in a 3-stage pipeline with
// per-channel history and refractory state. Detections are emitted as
// per-channel pulses and as {channel, timestamp} words in a FWFT event FIFO.
module processing_unit_neo_mc #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 4,
  parameter int REFRACT    = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [2*DATA_W-1:0]      thresh,
  output logic [NUM_CH-1:0]        spike_detection,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [31:0]              event_out,
  output logic [15:0]              drop_count
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // psi = a - b, one bit wider than the products so it can never overflow
  function automatic logic signed [PW:0] f_psi(input logic signed [PW-1:0] a,
                                               input logic signed [PW-1:0] b);
    return {a[PW-1], a} - {b[PW-1], b};
  endfunction

  // per-channel state
  logic signed [DATA_W-1:0] r_x1 [NUM_CH];
  logic signed [DATA_W-1:0] r_x2 [NUM_CH];
  logic [7:0]               r_rcnt [NUM_CH];
  logic [23:0]              r_ts;

  // pipeline registers
  logic                     r_vld_p1, r_vld_p2;
  logic [CH_W-1:0]          r_ch_p1, r_ch_p2;
  logic [23:0]              r_ts_p1, r_ts_p2;
  logic signed [DATA_W-1:0] r_x_p1, r_x1_p1, r_x2_p1;
  logic signed [PW-1:0]     r_a_p2, r_b_p2;
  logic [NUM_CH-1:0]        r_spike;

  // event FIFO
  logic [31:0]              r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr, r_rd;
  logic [CW-1:0]            r_cnt;
  logic [15:0]              r_drop;

  logic                     w_ch_ok, w_acc, w_hit;
  logic signed [PW:0]       w_psi, w_thr;
  logic                     w_full, w_pop, w_wr_en, w_drop;

  // channel indices beyond NUM_CH only exist when NUM_CH is not a power of 2
  generate
    if ((1 << CH_W) == NUM_CH) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_part
      assign w_ch_ok = (in_ch < CH_W'(NUM_CH));
    end
  endgenerate

  assign w_acc   = in_valid & w_ch_ok;
  assign w_psi   = f_psi(r_a_p2, r_b_p2);
  assign w_thr   = {1'b0, thresh};
  assign w_hit   = r_vld_p2 && (w_psi > 0) && (w_psi > w_thr) && (r_rcnt[r_ch_p2] == 8'd0);

  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop   = event_valid & event_ready;
  assign w_wr_en = w_hit & (~w_full | w_pop);
  assign w_drop  = w_hit & w_full & ~w_pop;

  // Stage 0: timestamp counter and per-channel history update on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ts <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
      end
    end else begin
      r_ts <= r_ts + 24'd1;
      if (w_acc) begin
        r_x2[in_ch] <= r_x1[in_ch];
        r_x1[in_ch] <= in_data;
      end
    end
  end

  // Pipeline valid flags; cleared by reset so in-flight samples are discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_acc;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Stage 0 -> 1: capture sample with its pre-update history
  always_ff @(posedge clk) begin
    r_x_p1  <= in_data;
    r_x1_p1 <= r_x1[in_ch];
    r_x2_p1 <= r_x2[in_ch];
    r_ch_p1 <= in_ch;
    r_ts_p1 <= r_ts;
  end

  // Stage 1 -> 2: full-width signed products
  always_ff @(posedge clk) begin
    r_a_p2  <= PW'(r_x1_p1) * PW'(r_x1_p1);
    r_b_p2  <= PW'(r_x_p1) * PW'(r_x2_p1);
    r_ch_p2 <= r_ch_p1;
    r_ts_p2 <= r_ts_p1;
  end

  // Stage 2: threshold decision, refractory counting and spike pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spike <= '0;
      for (int i = 0; i < NUM_CH; i++) r_rcnt[i] <= '0;
    end else begin
      r_spike <= '0;
      if (w_hit) r_spike[r_ch_p2] <= 1'b1;
      if (r_vld_p2) begin
        if (w_hit)
          r_rcnt[r_ch_p2] <= 8'(REFRACT);
        else if (r_rcnt[r_ch_p2] != 8'd0)
          r_rcnt[r_ch_p2] <= r_rcnt[r_ch_p2] - 8'd1;
      end
    end
  end

  // Event FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + AW'(1);
      if (w_pop)   r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_wr_en) - CW'(w_pop);
      if (w_drop) r_drop <= f_sat_inc16(r_drop);
    end
  end

  // Event FIFO storage
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= {8'(r_ch_p2), r_ts_p2};
  end

  assign spike_detection = r_spike;
  assign event_valid     = (r_cnt != '0);
  assign event_out       = event_valid ? r_mem[r_rd] : 32'd0;
  assign drop_count      = r_drop;

endmodule

// File: tb/tb_processing_unit_neo_mc.sv
// Testbench for processing_unit_neo_mc: directed vector table, hand-written
// multi-cycle sequences and randomized traffic checked against a
// cycle-level behavioural model of the NEO detector and event FIFO.
module tb_processing_unit_neo_mc;

  localparam int DATA_W     = 16;
  localparam int NUM_CH     = 5;
  localparam int REFRACT    = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int CH_W       = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic [CH_W-1:0]          in_ch = '0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic [2*DATA_W-1:0]      thresh = '0;
  logic [NUM_CH-1:0]        spike_detection;
  logic                     event_valid;
  logic                     event_ready = 1'b0;
  logic [31:0]              event_out;
  logic [15:0]              drop_count;

  processing_unit_neo_mc #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .REFRACT(REFRACT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .thresh(thresh), .spike_detection(spike_detection), .event_valid(event_valid),
    .event_ready(event_ready), .event_out(event_out), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint      m_h1 [NUM_CH];
  longint      m_h2 [NUM_CH];
  int          m_rc [NUM_CH];
  logic [31:0] m_q [$];
  int          m_drop;
  logic [23:0] m_ts;
  bit          d0_v, d1_v;
  int          d0_ch, d1_ch;
  longint      d0_psi, d1_psi;
  logic [23:0] d0_ts, d1_ts;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_h1[i] = 0; m_h2[i] = 0; m_rc[i] = 0;
    end
    m_q.delete();
    m_drop = 0; m_ts = '0;
    d0_v = 0; d1_v = 0;
  endtask

  // One clock: snapshot inputs, advance the model, compare every output.
  task automatic tick();
    bit pop, acc, hit;
    logic [31:0] th, head;
    int ch;
    longint d;
    logic [NUM_CH-1:0] esp;
    pop = event_ready && (m_q.size() > 0);
    th  = thresh;
    acc = in_valid && (int'(in_ch) < NUM_CH);
    ch  = int'(in_ch);
    d   = longint'(in_data);
    @(posedge clk); #1;
    esp = '0;
    if (pop) void'(m_q.pop_front());
    if (d1_v) begin
      hit = (d1_psi > 0) && (d1_psi > longint'(th)) && (m_rc[d1_ch] == 0);
      if (hit) begin
        m_rc[d1_ch] = REFRACT;
        esp[d1_ch] = 1'b1;
        if (m_q.size() < FIFO_DEPTH) m_q.push_back({8'(d1_ch), d1_ts});
        else if (m_drop < 65535) m_drop++;
      end else if (m_rc[d1_ch] != 0) begin
        m_rc[d1_ch]--;
      end
    end
    d1_v = d0_v; d1_ch = d0_ch; d1_psi = d0_psi; d1_ts = d0_ts;
    d0_v = acc;
    if (acc) begin
      d0_ch  = ch;
      d0_psi = m_h1[ch] * m_h1[ch] - d * m_h2[ch];
      d0_ts  = m_ts;
      m_h2[ch] = m_h1[ch];
      m_h1[ch] = d;
    end
    m_ts = m_ts + 24'd1;
    head = (m_q.size() > 0) ? m_q[0] : 32'd0;
    chk("spike", 32'(spike_detection), 32'(esp));
    chk("event_valid", 32'(event_valid), 32'(m_q.size() > 0));
    chk("event_out", event_out, head);
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic drive(input bit v, input int ch, input int d);
    in_valid = v;
    in_ch    = 3'(ch);
    in_data  = 16'(d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0);
    event_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_spike", 32'(spike_detection), 32'd0);
    chk("rst_valid", 32'(event_valid), 32'd0);
    chk("rst_out", event_out, 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int          ch;
    int          data;
    logic [31:0] thr;
    bit          exp_hit;
  } vec_t;

  localparam int NT = 20;
  vec_t tab [NT];

  initial begin
    logic [31:0] mask;
    logic [NUM_CH-1:0] sp_or;

    // ch/data/threshold-at-evaluation/expected detection
    tab[0]  = '{2, 0, 32'd100, 1'b0};
    tab[1]  = '{2, 0, 32'd100, 1'b0};
    tab[2]  = '{2, 20, 32'd100, 1'b0};        // psi = 0 (x1 = 0)
    tab[3]  = '{2, 0, 32'd100, 1'b1};         // psi = 400
    tab[4]  = '{2, 0, 32'd100, 1'b0};
    tab[5]  = '{3, 0, 32'd400, 1'b0};
    tab[6]  = '{3, 0, 32'd400, 1'b0};
    tab[7]  = '{3, 20, 32'd400, 1'b0};
    tab[8]  = '{3, 0, 32'd400, 1'b0};         // psi = 400 equals threshold
    tab[9]  = '{1, 5, 32'd0, 1'b0};           // psi = 0, not > 0
    tab[10] = '{1, 7, 32'd30, 1'b0};          // psi = 25
    tab[11] = '{5, 999, 32'd0, 1'b0};         // invalid channel
    tab[12] = '{1, 9, 32'd3, 1'b1};           // psi = 49 - 45 = 4
    tab[13] = '{0, 32767, 32'd0, 1'b0};
    tab[14] = '{0, -32768, 32'hFFFF_FFFF, 1'b0};
    tab[15] = '{0, -32768, 32'h8000_0000, 1'b0};  // psi = 2147450880
    tab[16] = '{0, 32767, 32'd2147450879, 1'b1};  // psi = 2147450880
    tab[17] = '{4, 3, 32'd0, 1'b0};
    tab[18] = '{4, 0, 32'd100, 1'b0};         // psi = 9
    tab[19] = '{4, 5, 32'd0, 1'b0};           // psi = -15

    do_reset();

    // quiet input: all-zero samples never detect
    thresh = 32'd0;
    for (int i = 0; i < 32; i++) begin
      drive(1, i % 4, 0);
      tick();
    end
    drive(0, 0, 0);
    tick(); tick();
    chk("quiet_valid", 32'(event_valid), 32'd0);

    // vector table, back-to-back across channels
    for (int i = 0; i < NT + 2; i++) begin
      if (i < NT) drive(1, tab[i].ch, tab[i].data);
      else drive(0, 0, 0);
      if (i >= 2) thresh = tab[i-2].thr;
      tick();
      if (i >= 2)
        chk($sformatf("vec%0d", i - 2), 32'(spike_detection),
            tab[i-2].exp_hit ? (32'd1 << tab[i-2].ch) : 32'd0);
    end
    // first stored event: ch2 sample accepted at timestamp 34 + 3
    chk("ch2_event", event_out, {8'd2, 24'd37});
    event_ready = 1'b1;
    repeat (4) tick();
    event_ready = 1'b0;

    // refractory: ramp on ch0 gives constant psi = 1e6 from the 3rd sample on
    do_reset();
    thresh = 32'd500000;
    event_ready = 1'b1;
    mask = '0;
    for (int j = 0; j < 22; j++) begin
      if (j >= 20) drive(0, 0, 0);
      else if (j % 2 == 0) drive(1, 0, (j / 2) * 1000);
      else drive(1, 1, int'($urandom_range(0, 2000)) - 1000);
      tick();
      if (spike_detection[0]) mask[j] = 1'b1;
    end
    chk("refract_mask", mask, 32'h0000_4040);

    // FIFO overflow: 11 detections at k = 2, 6, ..., 42 into an 8-deep FIFO
    do_reset();
    thresh = 32'd5000;
    for (int k = 0; k <= 42; k++) begin
      drive(1, 0, 100 * k);
      tick();
    end
    drive(0, 0, 0);
    tick(); tick();
    chk("ovf_valid", 32'(event_valid), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd3);
    event_ready = 1'b1;
    for (int m = 0; m < 8; m++) begin
      chk($sformatf("drain%0d", m), event_out, {8'd0, 24'(2 + 4 * m)});
      tick();
    end
    event_ready = 1'b0;
    chk("drained", 32'(event_valid), 32'd0);

    // full FIFO with push and pop on the same edge
    do_reset();
    thresh = 32'd5000;
    for (int k = 0; k <= 34; k++) begin
      drive(1, 0, 100 * k);
      tick();
    end
    drive(0, 0, 0);
    tick();
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    chk("pp_drops", 32'(drop_count), 32'd0);
    chk("pp_head", event_out, {8'd0, 24'd6});
    event_ready = 1'b1;
    repeat (10) tick();
    event_ready = 1'b0;
    chk("pp_empty", 32'(event_valid), 32'd0);

    // timestamp wrap: samples at 0xFFFFFE, 0xFFFFFF, 0x000000
    do_reset();
    thresh = 32'd5000;
    force dut.r_ts = 24'hFF_FFFE;
    #1;
    release dut.r_ts;
    m_ts = 24'hFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      drive(1, 3, 100 * k);
      tick();
    end
    drive(0, 0, 0);
    tick(); tick();
    chk("wrap_event", event_out, {8'd3, 24'd0});

    // reset mid-stream with an event stored and a detection in flight
    for (int k = 0; k < 7; k++) begin
      drive(1, 1, 100 * k);
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0);
    #1;
    chk("mid_spike", 32'(spike_detection), 32'd0);
    chk("mid_valid", 32'(event_valid), 32'd0);
    chk("mid_out", event_out, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    sp_or = '0;
    repeat (6) begin
      tick();
      sp_or = sp_or | spike_detection;
    end
    chk("no_stale", 32'(sp_or), 32'd0);

    // randomized traffic against the model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      if (t % 64 == 0) begin
        case ($urandom_range(0, 3))
          0:       thresh = 32'd0;
          1:       thresh = $urandom_range(0, 2000);
          2:       thresh = $urandom;
          default: thresh = 32'hFFFF_FFFF;
        endcase
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_ch    = 3'($urandom_range(0, 7));
      in_data  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                             : 16'(int'($urandom_range(0, 128)) - 64);
      event_ready = ((t / 500) % 2 == 0) ? ($urandom_range(0, 7) == 0)
                                         : ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
